// File: rtl/alu_pkg.sv
// Shared op-code, FSM state and decode helpers for the registered RV32 ALU
// with iterative multiply/divide.
package alu_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLT    = 5'd5,
        OP_SLTU   = 5'd6,
        OP_SLL    = 5'd7,
        OP_SRL    = 5'd8,
        OP_SRA    = 5'd9,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_e;

    // Codes 16..23 form the RV32M group
    function automatic logic is_multicycle(input logic [OP_W-1:0] op);
        return op[4] && !op[3];
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return is_multicycle(op) && op[2];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider working on
// operand magnitudes, with the sign fix applied to the final step's value.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  start,
    input  logic [OP_W-1:0]       op,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int N     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic               neg_q, neg_d, neg_r_q, neg_r_d, sel_q, sel_d;

    logic               s1, s2;
    logic [N-1:0]       mag1, mag2;
    logic [N:0]         mul_sum;
    logic [N-1:0]       mul_hi_n, mul_lo_n;
    logic [N:0]         rem_sh;
    logic [N-1:0]       rem_diff;
    logic               ge;
    logic [N-1:0]       div_r_n, div_q_n;
    logic [2*N-1:0]     prod, prod_fix;
    logic [N-1:0]       quot_fix, rem_fix;

    always_comb begin
        s1   = op1[N-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
        s2   = op2[N-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
        mag1 = s1 ? -op1 : op1;
        mag2 = s2 ? -op2 : op2;

        // Multiply: hi accumulates, lo shifts the multiplier out and the product in
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_n = mul_sum[N:1];
        mul_lo_n = {mul_sum[0], lo_q[N-1:1]};

        // Divide: hi is the partial remainder, lo shifts dividend out and quotient in
        rem_sh   = {hi_q, lo_q[N-1]};
        rem_diff = rem_sh[N-1:0] - opnd_q;
        ge       = rem_sh >= {1'b0, opnd_q};
        div_r_n  = ge ? rem_diff : rem_sh[N-1:0];
        div_q_n  = {lo_q[N-2:0], ge};

        prod     = {mul_hi_n, mul_lo_n};
        prod_fix = neg_q ? -prod : prod;
        quot_fix = neg_q ? -div_q_n : div_q_n;
        rem_fix  = neg_r_q ? -div_r_n : div_r_n;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        neg_r_d = neg_r_q;
        sel_d   = sel_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_d = CNT_W'(N - 1);
                        hi_d  = '0;
                        neg_d = s1 ^ s2;
                        if (op[2]) begin
                            state_d = ST_DIV;
                            lo_d    = mag1;
                            opnd_d  = mag2;
                            neg_r_d = s1;
                            sel_d   = op[1];
                        end else begin
                            state_d = ST_MUL;
                            lo_d    = mag2;
                            opnd_d  = mag1;
                            neg_r_d = 1'b0;
                            sel_d   = (op[1:0] != 2'b00);
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    hi_d = (state_q == ST_MUL) ? mul_hi_n : div_r_n;
                    lo_d = (state_q == ST_MUL) ? mul_lo_n : div_q_n;
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            neg_r_q <= neg_r_d;
            sel_q   <= sel_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = busy && (cnt_q == '0) && !flush;
    assign result = (state_q == ST_MUL) ? (sel_q ? prod_fix[2*N-1:N] : prod_fix[N-1:0])
                                        : (sel_q ? rem_fix : quot_fix);

endmodule

// File: rtl/alu_muldiv.sv
// Registered RV32 ALU with valid/ready handshake: single-cycle logic/arith ops
// plus an iterative RV32M unit, with result flags for the branch unit.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [CTRL_WIDTH-1:0] ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  lt,
    output logic                  ltu
);

    localparam int N    = DATA_WIDTH;
    localparam int SH_W = $clog2(DATA_WIDTH);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

    logic [OP_W-1:0] op;
    logic [SH_W-1:0] shamt;
    logic [N-1:0]    alu_res, iter_res;
    logic            lt_now, ltu_now, div_zero, div_ovf, special;
    logic            accept, out_fire, start, busy, done;

    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    result_q, result_d;
    logic            zero_q, zero_d, lt_q, lt_d, ltu_q, ltu_d;
    logic            lt_pend_q, lt_pend_d, ltu_pend_q, ltu_pend_d;

    muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .start  (start),
        .op     (op),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .done   (done),
        .result (iter_res)
    );

    assign in_ready = !busy && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        // Codes wider than the enum fall into the unlisted (pass op1) bucket
        op       = ((ctrl >> OP_W) == '0) ? ctrl[OP_W-1:0] : '1;
        shamt    = op2[SH_W-1:0];
        lt_now   = $signed(op1) < $signed(op2);
        ltu_now  = op1 < op2;
        div_zero = (op2 == '0);
        div_ovf  = (op1 == MIN_NEG) && (op2 == '1) && (op == OP_DIV || op == OP_REM);
        special  = is_div(op) && (div_zero || div_ovf);
        start    = accept && is_multicycle(op) && !special;

        case (op)
            OP_ADD:           alu_res = op1 + op2;
            OP_SUB:           alu_res = op1 - op2;
            OP_AND:           alu_res = op1 & op2;
            OP_OR:            alu_res = op1 | op2;
            OP_XOR:           alu_res = op1 ^ op2;
            OP_SLT:           alu_res = N'(lt_now);
            OP_SLTU:          alu_res = N'(ltu_now);
            OP_SLL:           alu_res = op1 << shamt;
            OP_SRL:           alu_res = op1 >> shamt;
            OP_SRA:           alu_res = $unsigned($signed(op1) >>> shamt);
            // Only reached for divide-by-zero or signed overflow
            OP_DIV, OP_DIVU:  alu_res = div_zero ? '1 : op1;
            OP_REM, OP_REMU:  alu_res = div_zero ? op1 : '0;
            default:          alu_res = op1;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        lt_d        = lt_q;
        ltu_d       = ltu_q;
        lt_pend_d   = lt_pend_q;
        ltu_pend_d  = ltu_pend_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (done) begin
            out_valid_d = 1'b1;
            result_d    = iter_res;
            zero_d      = (iter_res == '0);
            lt_d        = lt_pend_q;
            ltu_d       = ltu_pend_q;
        end else if (accept && !start) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            lt_d        = lt_now;
            ltu_d       = ltu_now;
        end else begin
            if (out_fire) begin
                out_valid_d = 1'b0;
            end
            // Flags compare the operands as captured, not the iterated magnitudes
            if (start) begin
                lt_pend_d  = lt_now;
                ltu_pend_d = ltu_now;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            lt_q        <= 1'b0;
            ltu_q       <= 1'b0;
            lt_pend_q   <= 1'b0;
            ltu_pend_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            lt_q        <= lt_d;
            ltu_q       <= ltu_d;
            lt_pend_q   <= lt_pend_d;
            ltu_pend_q  <= ltu_pend_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign lt        = lt_q;
    assign ltu       = ltu_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vectors, handshake corner cases
// and randomized ops against a plain-arithmetic reference model.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic         zero, lt, ltu;
    logic [W-1:0] op1, op2, result;
    logic [4:0]   ctrl;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.DATA_WIDTH(W), .CTRL_WIDTH(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .lt        (lt),
        .ltu       (ltu)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // RV32 semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_res(input int op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return (sa < sb) ? 32'd1 : 32'd0;
            6:  return (ua < ub) ? 32'd1 : 32'd0;
            7:  return 32'(ua << b[4:0]);
            8:  return 32'(ua >> b[4:0]);
            9:  begin q = sa >>> b[4:0]; return q[31:0]; end
            16: begin p = sa * sb; return p[31:0]; end
            17: begin p = sa * sb; return p[63:32]; end
            18: begin p = sa * longint'(ub); return p[63:32]; end
            19: begin p = ua * ub; return p[63:32]; end
            20: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = sa / sb; return q[31:0];
            end
            21: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            22: begin
                if (b == 0) return a;
                q = sa % sb; return q[31:0];
            end
            23: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
            default: return a;
        endcase
    endfunction

    function automatic bit ref_multicycle(input int op, input logic [31:0] a, input logic [31:0] b);
        if (op >= 16 && op <= 19) return 1'b1;
        if (op >= 20 && op <= 23) begin
            if (b == 0) return 1'b0;
            if ((op == 20 || op == 22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Issue one op with out_ready=1 and check result, flags, latency and busy time
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        int low;
        bit mc;
        mc = ref_multicycle(int'(op), a, b);
        @(negedge clk);
        in_valid = 1'b1;
        ctrl     = op;
        op1      = a;
        op2      = b;
        cyc      = 0;
        while (!in_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) begin
            check({tag, " accept_timeout"}, 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op1      = $urandom;
        op2      = $urandom;
        cyc      = 0;
        low      = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!out_valid && !in_ready) low++;
        end while (!out_valid && cyc < 200);
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        // Accept edge plus W busy edges for iterative ops
        check({tag, " latency"}, 64'(cyc), mc ? 64'(W + 1) : 64'd1);
        check({tag, " busy_cycles"}, 64'(low), mc ? 64'(W) : 64'd0);
        check({tag, " result"}, 64'(result), 64'(exp));
        check({tag, " zero"}, 64'(zero), 64'(exp == 0));
        check({tag, " lt"}, 64'(lt), 64'($signed(a) < $signed(b)));
        check({tag, " ltu"}, 64'(ltu), 64'(a < b));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t dir [20] = '{
        '{5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000},
        '{5'd9,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000},
        '{5'd6,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001},
        '{5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
        '{5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{5'd20, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{5'd22, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{5'd21, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
        '{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
        '{5'd23, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
        '{5'd16, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{5'd23, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002},
        '{5'd21, 32'hFFFF_FFFF, 32'h0000_0003, 32'h5555_5555},
        '{5'd4,  32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5},
        '{5'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
        '{5'd7,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000},
        '{5'd8,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001},
        '{5'd12, 32'h1234_5678, 32'h0000_0009, 32'h1234_5678}
    };

    int ops [19] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 21, 22, 23, 12};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        logic [4:0]  rop;
        logic [31:0] ra, rb;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ctrl      = 5'd0;
        op1       = '0;
        op2       = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset flags", 64'({zero, lt, ltu}), 64'd0);
        rst_n = 1'b1;

        foreach (dir[i]) begin
            run_op($sformatf("dir%0d op%0d", i, dir[i].op), dir[i].op, dir[i].a, dir[i].b, dir[i].r);
        end

        // Backpressure: second ADD must stall while the first is held
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ctrl      = 5'd0;
        op1       = 32'd10;
        op2       = 32'd20;
        @(posedge clk);
        #1;
        op1 = 32'd3;
        op2 = 32'd4;
        repeat (3) begin
            @(negedge clk);
            check("bp held result", 64'(result), 64'd30);
            check("bp held valid", 64'(out_valid), 64'd1);
            check("bp in_ready low", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp second result", 64'(result), 64'd7);
        check("bp second valid", 64'(out_valid), 64'd1);
        check("bp second lt", 64'(lt), 64'd1);

        // Flush in the middle of a DIVU
        @(negedge clk);
        in_valid = 1'b1;
        ctrl     = 5'd21;
        op1      = 32'd1000;
        op2      = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        ctrl     = 5'd0;
        op1      = 32'd1;
        op2      = 32'd1;
        #1;
        check("flush in_ready low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush in_ready after", 64'(in_ready), 64'd1);
        check("flush out_valid after", 64'(out_valid), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("flush no late result", 64'(seen), 64'd0);

        // Asynchronous reset mid-MUL
        @(negedge clk);
        in_valid = 1'b1;
        ctrl     = 5'd16;
        op1      = 32'd123;
        op2      = 32'd456;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst result", 64'(result), 64'd0);
        check("async rst flags", 64'({zero, lt, ltu}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("post rst no result", 64'(seen), 64'd0);

        for (int i = 0; i < 60; i++) begin
            rop = 5'(ops[$urandom_range(0, 18)]);
            ra  = pick_operand();
            rb  = pick_operand();
            run_op($sformatf("rand%0d op%0d a=%h b=%h", i, rop, ra, rb), rop, ra, rb,
                   ref_res(int'(rop), ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
